// File: rtl/data_receiver.sv
`timescale 1ns/1ps
// data_receiver: clkb-side endpoint of a 4-phase req/ack bundled-data crossing.
// Synchronizes the request, captures the held word, checks its sequence and counts words.
//
// state    | meaning
// IDLE     | ack low, waiting for synchronized req
// HOLD     | ack high, minimum-hold down-counter running
// WAIT_LOW | ack high, waiting for synchronized req to drop
module data_receiver #(
    parameter int N        = 4,
    parameter int ACK_HOLD = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clkb_i,
    input  logic             rst_n_i,
    input  logic             data_req_i,
    input  logic [N-1:0]     data_i,
    output logic             data_ack_o,
    output logic [N-1:0]     rx_data_o,
    output logic             rx_valid_o,
    output logic [CNT_W-1:0] rx_count_o,
    output logic             seq_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HOLD     = 2'b01,
        WAIT_LOW = 2'b10
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(ACK_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic             req_s1_q, req_s2_q;
    logic             data_ack_q, data_ack_d;
    logic [N-1:0]     rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0] rx_count_q, rx_count_d;
    logic             seq_err_q, seq_err_d;
    logic [N-1:0]     expected_q, expected_d;

    always_ff @(posedge clkb_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
        end else begin
            req_s1_q <= data_req_i;
            req_s2_q <= req_s1_q;
        end
    end

    always_ff @(posedge clkb_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            data_ack_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_count_q <= '0;
            seq_err_q  <= 1'b0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            data_ack_q <= data_ack_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_count_q <= rx_count_d;
            seq_err_q  <= seq_err_d;
            expected_q <= expected_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        data_ack_d = data_ack_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_count_d = rx_count_q;
        seq_err_d  = seq_err_q;
        expected_d = expected_q;
        case (state_q)
            IDLE: begin
                data_ack_d = 1'b0;
                // data_i is only trusted once the synchronized req says it is held
                if (req_s2_q) begin
                    rx_data_d  = data_i;
                    rx_valid_d = 1'b1;
                    data_ack_d = 1'b1;
                    hold_cnt_d = HOLD_INIT;
                    rx_count_d = rx_count_q + CNT_W'(1);
                    if (data_i != expected_q) seq_err_d = 1'b1;
                    expected_d = data_i + N'(1);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                data_ack_d = 1'b1;
                if (hold_cnt_q == 4'd0) state_d = WAIT_LOW;
                else                     hold_cnt_d = hold_cnt_q - 4'd1;
            end
            WAIT_LOW: begin
                data_ack_d = 1'b1;
                if (!req_s2_q) begin
                    data_ack_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                data_ack_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign data_ack_o = data_ack_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_count_o = rx_count_q;
    assign seq_err_o  = seq_err_q;

endmodule

// File: doc/data_receiver.md
Name: data_receiver

Overview:
- Destination side of the 4-phase req/ack bundled-data crossing; sits directly downstream of the clka-domain sender, in the clkb domain.
- Synchronizes data_req, captures the held data word, and returns data_ack with full 4-phase sequencing.
- Presents each word as a one-cycle valid strobe to local logic.
- Checks the sender's incrementing sequence and counts received words.

Parameters:
N, 4, data width; must match the sender.
ACK_HOLD, 2, minimum clkb cycles data_ack stays high; legal range 1..15.
CNT_W, 8, width of rx_count.

Ports:
clkb  input  1  receive-domain clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
data_req  input  1  request from the clka domain; asynchronous to clkb.
data  input  N  bundled data from the sender; stable whenever data_req is high.
data_ack  output  1  acknowledge to the sender; registered.
rx_data  output  N  last captured word.
rx_valid  output  1  one-cycle strobe when rx_data updates.
rx_count  output  CNT_W  number of words received; wraps.
seq_err  output  1  sticky flag: a received word was not the expected word.

Behaviour:
- Reset (async, active-low):
  - data_ack=0, rx_data=0, rx_valid=0, rx_count=0, seq_err=0.
  - Synchronizer flops = 0, FSM=IDLE, expected word=0.
- Synchronizer:
  - 2-flop chain on data_req: req_s1 then req_s2.
  - Only req_s2 is used by logic.
  - data is never synchronized; it is sampled only while req_s2=1 (bundled-data rule).
- FSM states: IDLE, HOLD, WAIT_LOW.
  - IDLE: data_ack=0. On req_s2=1:
    - rx_data<=data, rx_valid<=1, data_ack<=1.
    - Load hold counter with ACK_HOLD-1; go to HOLD.
  - HOLD: data_ack=1. Hold counter decrements each cycle. When it reaches 0, go to WAIT_LOW.
  - WAIT_LOW: data_ack=1. On req_s2=0: data_ack<=0; go to IDLE.
  - If req_s2 is already 0 on HOLD exit, WAIT_LOW still lasts one cycle before ack drops. No shortcut.
  - Unused state encodings recover to IDLE with data_ack=0.
- Latency:
  - data_req rise at clkb edge k appears on req_s2 after edge k+1.
  - Capture and data_ack rise occur at edge k+2. rx_valid is high for the cycle after edge k+2.
  - data_ack fall occurs 2-3 clkb edges after data_req falls, and never sooner than ACK_HOLD+1 cycles after it rose.
- rx_valid:
  - Exactly one cycle per handshake.
  - Never asserted in HOLD or WAIT_LOW.
  - A req that stays high for a long time gives a single capture.
- Sequence check:
  - At capture, compare data against the expected word.
  - On mismatch, seq_err<=1 and it stays 1 until reset.
  - After every capture, expected<=data+1 mod 2^N, so the checker resynchronizes after an error.
  - Wrap is legal: 2^N-1 followed by 0 is not an error.
- rx_count increments by 1 at each capture and wraps 2^CNT_W-1 -> 0.
- New req during ack high: this is protocol-illegal. If req_s2 is high again after data_ack falls, it is captured as a new word from IDLE on the next edge.
- Reset mid-handshake: data_ack drops immediately (asynchronous). The sender's ack edge detector sees no rising edge, so that word is re-sent and re-captured after reset.

Test Plan:
- Nominal, N=4, sender 5-cycle gap, clkb = 1.7 x clka: 20 handshakes.
  - Required: rx_data sequence 0,1,...,15,0,1,2,3.
  - rx_valid pulses = 20, rx_count=20, seq_err=0.
  - No data_ack rising edge while data_req=0 in a new cycle.
- Latency, directly driven: data_req rises at edge 10.
  - data_ack=1 after edge 12; rx_valid high only in cycle 12-13.
  - data_req dropped at edge 14 with ACK_HOLD=2: data_ack=0 after edge 16.
- ACK_HOLD=5, req dropped 1 cycle after ack rises: data_ack stays high at least 6 cycles, then falls. Exactly one rx_valid.
- Sequence fault: drive words 0,1,3,4.
  - seq_err rises at the capture of 3 and stays 1.
  - rx_count=4 at the end.
  - After a subsequent reset, seq_err=0.
- Reset while in WAIT_LOW with data_req=1.
  - data_ack=0 asynchronously; all outputs at reset values.
  - After release, the held req is captured again: rx_count=1 and rx_valid pulses once.
- Slow receiver, clkb = 0.4 x clka: 10 handshakes captured in order 0..9, seq_err=0, no missed or duplicated rx_valid.
